// File: rtl/serial_compare_pkg.sv
// Shared constants for the MSB-first serial magnitude comparator:
// the default operand width and the FSM state encodings.
package serial_compare_pkg;

  localparam int unsigned CmpWidthDefault = 8;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StRun  = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

endpackage

// File: rtl/serial_compare_bit_cell.sv
// Combinational single-bit magnitude decision for one A/B bit pair.
module cmp_bit_cell (
  input  logic a,
  input  logic b,
  output logic gt,
  output logic eq,
  output logic lt
);

  assign gt = a & ~b;
  assign eq = ~(a ^ b);
  assign lt = ~a & b;

endmodule

// File: rtl/serial_compare.sv
// MSB-first serial comparator: accepts WIDTH bit pairs after start, then
// pulses done with a registered one-hot gt/eq/lt result.
module serial_compare
  import serial_compare_pkg::*;
#(
  parameter int unsigned WIDTH = CmpWidthDefault
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic in_valid,
  input  logic a_bit,
  input  logic b_bit,
  output logic in_ready,
  output logic done,
  output logic a_gt_b,
  output logic a_eq_b,
  output logic a_lt_b
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  logic [1:0]      r_state, w_state_nxt;
  logic [CntW-1:0] r_cnt, w_cnt_nxt;
  logic            r_gt, r_eq, r_lt;
  logic            w_gt_nxt, w_eq_nxt, w_lt_nxt;
  logic            r_a_gt_b, r_a_eq_b, r_a_lt_b;
  logic            w_out_load;
  logic            w_accept;
  logic            w_cell_gt, w_cell_eq, w_cell_lt;

  cmp_bit_cell u_cell (
    .a  (a_bit),
    .b  (b_bit),
    .gt (w_cell_gt),
    .eq (w_cell_eq),
    .lt (w_cell_lt)
  );

  assign in_ready = (r_state == StRun);
  assign done     = (r_state == StDone);
  assign w_accept = in_valid & in_ready;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_gt_nxt    = r_gt;
    w_eq_nxt    = r_eq;
    w_lt_nxt    = r_lt;
    w_out_load  = 1'b0;
    case (r_state)
      StIdle: begin
        if (start) begin
          w_cnt_nxt   = '0;
          w_gt_nxt    = 1'b0;
          w_eq_nxt    = 1'b1;
          w_lt_nxt    = 1'b0;
          w_state_nxt = StRun;
        end
      end
      StRun: begin
        if (w_accept) begin
          w_cnt_nxt = r_cnt + CntW'(1);
          // First differing bit decides; later bits are counted only.
          if (r_eq) begin
            w_gt_nxt = w_cell_gt;
            w_eq_nxt = w_cell_eq;
            w_lt_nxt = w_cell_lt;
          end
          if (r_cnt == LastCnt) begin
            w_state_nxt = StDone;
            w_out_load  = 1'b1;
          end
        end
      end
      StDone:  w_state_nxt = StIdle;
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= StIdle;
      r_cnt    <= '0;
      r_gt     <= 1'b0;
      r_eq     <= 1'b0;
      r_lt     <= 1'b0;
      r_a_gt_b <= 1'b0;
      r_a_eq_b <= 1'b0;
      r_a_lt_b <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_gt    <= w_gt_nxt;
      r_eq    <= w_eq_nxt;
      r_lt    <= w_lt_nxt;
      if (w_out_load) begin
        r_a_gt_b <= w_gt_nxt;
        r_a_eq_b <= w_eq_nxt;
        r_a_lt_b <= w_lt_nxt;
      end
    end
  end

  assign a_gt_b = r_a_gt_b;
  assign a_eq_b = r_a_eq_b;
  assign a_lt_b = r_a_lt_b;

endmodule
